// File: rtl/ram_rd_ctrl.sv
// Spectrum RAM reader: sweeps ADDR_START..ADDR_END and streams magnitudes with bin index.
// Optional peak tracking is enabled by defining PEAK_SEARCH_EN.
module ram_rd_ctrl #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 16,
    parameter int ADDR_START   = 0,
    parameter int ADDR_END     = 2102,
    parameter int RD_LAT       = 2,
    parameter int PEAK_MIN_BIN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] dout_bin,
    output logic              dout_valid,
    output logic              busy,
    output logic              rd_done,
    output logic [DATA_W-1:0] peak_mag,
    output logic [ADDR_W-1:0] peak_bin
);

    if (ADDR_START < 0 || ADDR_END >= (1 << ADDR_W) || ADDR_START > ADDR_END)
    begin : g_bad_range
        $error("ram_rd_ctrl: ADDR_START/ADDR_END outside ADDR_W range");
    end

    if (RD_LAT < 1 || RD_LAT > 4 || PEAK_MIN_BIN < 0) begin : g_bad_lat
        $error("ram_rd_ctrl: RD_LAT must be 1..4, PEAK_MIN_BIN >= 0");
    end

    localparam logic [ADDR_W-1:0] LP_START = ADDR_W'(ADDR_START);
    localparam logic [ADDR_W-1:0] LP_END   = ADDR_W'(ADDR_END);
    localparam logic [2:0]        LP_LAST  = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_start_q;
    logic              w_go;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_en;
    logic              w_en_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic [RD_LAT-1:0] r_vld_sr;
    logic [ADDR_W-1:0] r_bin_sr [RD_LAT];

    assign w_go = start & ~r_start_q;

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_en_nxt    = r_en;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (w_go) begin
                    w_state_nxt = S_READ;
                    w_addr_nxt  = LP_START;
                    w_en_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                end
            end
            S_READ: begin
                if (r_addr == LP_END) begin
                    w_en_nxt    = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_addr_nxt = r_addr + 1'b1;
                end
            end
            S_DRAIN: begin
                // Wait out the RAM latency so the final word leaves the pipe first
                if (r_cnt == LP_LAST) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_addr    <= '0;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= start;
            r_addr    <= w_addr_nxt;
            r_en      <= w_en_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_sr <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_bin_sr[i] <= '0;
            end
        end else begin
            r_vld_sr[0] <= r_en;
            r_bin_sr[0] <= r_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_sr[i] <= r_vld_sr[i-1];
                r_bin_sr[i] <= r_bin_sr[i-1];
            end
        end
    end

    assign rd_addr    = r_addr;
    assign rd_en      = r_en;
    assign busy       = r_busy;
    assign rd_done    = r_done;
    assign dout_valid = r_vld_sr[RD_LAT-1];
    assign dout_bin   = r_bin_sr[RD_LAT-1];
    // Gate data so stale RAM output never shows outside a valid word
    assign dout       = dout_valid ? ram_dout : '0;

`ifdef PEAK_SEARCH_EN
    localparam logic [ADDR_W-1:0] LP_MIN = ADDR_W'(PEAK_MIN_BIN);

    logic              w_launch;
    logic              r_first;
    logic [DATA_W-1:0] r_pk_mag;
    logic [ADDR_W-1:0] r_pk_bin;
    logic [DATA_W-1:0] w_base_mag;
    logic [ADDR_W-1:0] w_base_bin;
    logic              w_take;

    assign w_launch = w_go && (r_state == S_IDLE || r_state == S_DONE);

    always_comb begin
        w_base_mag = r_first ? '0 : r_pk_mag;
        w_base_bin = r_first ? '0 : r_pk_bin;
        w_take     = dout_valid && (dout_bin >= LP_MIN) && (dout > w_base_mag);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_first  <= 1'b0;
            r_pk_mag <= '0;
            r_pk_bin <= '0;
        end else begin
            if (w_launch) begin
                r_first <= 1'b1;
            end
            if (dout_valid) begin
                r_first  <= 1'b0;
                r_pk_mag <= w_take ? dout : w_base_mag;
                r_pk_bin <= w_take ? dout_bin : w_base_bin;
            end
        end
    end

    assign peak_mag = r_pk_mag;
    assign peak_bin = r_pk_bin;
`else
    assign peak_mag = '0;
    assign peak_bin = '0;
`endif

endmodule
